// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: merges in-order pipeline writebacks with
// buffered mult/div results, filtering r0/r1 and redirecting exceptions to r30.
module writeback_arbiter #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] MULT_EXC = 32'd4,
  parameter logic [31:0] DIV_EXC  = 32'd5
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        pipe_stall,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  input  logic        md_op,
  input  logic        md_exception,
  input  logic [4:0]  query_rs,
  input  logic [4:0]  query_rt,
  output logic        hazard,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_PIPE,
    SLOT_DRAIN,
    SLOT_FULL
  } slot_e;

  logic [4:0]       rd_mem   [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic        full;
  logic        wb_write;
  logic        md_push;
  logic        pop;
  logic [4:0]  push_rd;
  logic [31:0] push_data;
  slot_e       slot;

  assign full       = (count == CNT_W'(DEPTH));
  assign md_ready   = ~full;
  assign pipe_stall = full;

  // r0 and r1 are not writable; an exception always targets r30 and so survives.
  assign wb_write  = wb_valid && (wb_rd[4:1] != 4'd0);
  assign md_push   = md_valid && md_ready && (md_exception || (md_rd[4:1] != 4'd0));
  assign push_rd   = md_exception ? 5'd30 : md_rd;
  assign push_data = md_exception ? (md_op ? DIV_EXC : MULT_EXC) : md_data;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    slot = SLOT_IDLE;
    if (full)
      slot = SLOT_FULL;
    else if (wb_write)
      slot = SLOT_PIPE;
    else if (count != '0)
      slot = SLOT_DRAIN;
  end

  assign pop = (slot == SLOT_FULL) || (slot == SLOT_DRAIN);

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] age;
      age = PTR_W'(i) - rd_ptr;
      if ((CNT_W'(age) < count) &&
          ((rd_mem[i] == query_rs) || (rd_mem[i] == query_rt)))
        hazard = 1'b1;
    end
  end

  // NOTE: the payload storage has no reset; occupancy is tracked by count, so
  // stale contents are never observed.
  always_ff @(posedge clock) begin
    if (md_push) begin
      rd_mem[wr_ptr]   <= push_rd;
      data_mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= 5'd0;
      data_writeReg    <= 32'd0;
    end else begin
      if (md_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(md_push) - CNT_W'(pop);

      // Address/data hold their last value when nothing is written.
      unique case (slot)
        SLOT_PIPE: begin
          ctrl_writeEnable <= 1'b1;
          ctrl_writeReg    <= wb_rd;
          data_writeReg    <= wb_data;
        end
        SLOT_FULL, SLOT_DRAIN: begin
          ctrl_writeEnable <= 1'b1;
          ctrl_writeReg    <= rd_mem[rd_ptr];
          data_writeReg    <= data_mem[rd_ptr];
        end
        default: ctrl_writeEnable <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: a queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_writeback_arbiter;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        pipe_stall;
  logic        md_valid = 1'b0;
  logic        md_ready;
  logic [4:0]  md_rd = '0;
  logic [31:0] md_data = '0;
  logic        md_op = 1'b0;
  logic        md_exception = 1'b0;
  logic [4:0]  query_rs = '0;
  logic [4:0]  query_rt = '0;
  logic        hazard;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  writeback_arbiter #(
    .DEPTH(DEPTH), .MULT_EXC(32'd4), .DIV_EXC(32'd5)
  ) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .pipe_stall(pipe_stall),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd),
    .md_data(md_data), .md_op(md_op), .md_exception(md_exception),
    .query_rs(query_rs), .query_rt(query_rt), .hazard(hazard),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered results as a queue of {rd, data}.
  logic [36:0] q[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_reg = '0;
  logic [31:0] m_data = '0;

  always @(posedge clock or posedge ctrl_reset) begin
    int          sz;
    logic [36:0] head;
    if (ctrl_reset) begin
      q.delete();
      m_we   <= 1'b0;
      m_reg  <= '0;
      m_data <= '0;
    end else begin
      sz = q.size();
      if (sz == DEPTH || (!(wb_valid && wb_rd > 5'd1) && sz > 0)) begin
        head = q.pop_front();
        m_we   <= 1'b1;
        m_reg  <= head[36:32];
        m_data <= head[31:0];
      end else if (wb_valid && wb_rd > 5'd1) begin
        m_we   <= 1'b1;
        m_reg  <= wb_rd;
        m_data <= wb_data;
      end else begin
        m_we <= 1'b0;
      end
      if (md_valid && sz != DEPTH) begin
        if (md_exception)
          q.push_back({5'd30, (md_op ? 32'd5 : 32'd4)});
        else if (md_rd > 5'd1)
          q.push_back({md_rd, md_data});
      end
    end
  end

  function automatic logic model_hazard();
    foreach (q[i])
      if (q[i][36:32] == query_rs || q[i][36:32] == query_rt)
        return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      #2;
      check("cmp_we",     32'(ctrl_writeEnable), 32'(m_we));
      check("cmp_reg",    32'(ctrl_writeReg),    32'(m_reg));
      check("cmp_data",   data_writeReg,         m_data);
      check("cmp_ready",  32'(md_ready),         32'(q.size() != DEPTH));
      check("cmp_stall",  32'(pipe_stall),       32'(q.size() == DEPTH));
      check("cmp_hazard", 32'(hazard),           32'(model_hazard()));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
    wb_valid = v;
    wb_rd    = rd;
    wb_data  = d;
  endtask

  task automatic set_md(input logic v, input logic [4:0] rd, input logic [31:0] d,
                        input logic op, input logic exc);
    md_valid     = v;
    md_rd        = rd;
    md_data      = d;
    md_op        = op;
    md_exception = exc;
  endtask

  task automatic check_write(input string name, input logic [4:0] rd, input logic [31:0] d);
    check({name, "_we"},   32'(ctrl_writeEnable), 32'd1);
    check({name, "_reg"},  32'(ctrl_writeReg),    32'(rd));
    check({name, "_data"}, data_writeReg,         d);
  endtask

  initial begin
    // Asynchronous reset asserted between clock edges.
    #2 ctrl_reset = 1'b1;
    #1;
    check("rst_we",     32'(ctrl_writeEnable), 32'd0);
    check("rst_reg",    32'(ctrl_writeReg),    32'd0);
    check("rst_data",   data_writeReg,         32'd0);
    check("rst_ready",  32'(md_ready),         32'd1);
    check("rst_stall",  32'(pipe_stall),       32'd0);
    check("rst_hazard", 32'(hazard),           32'd0);
    tick();
    tick();
    ctrl_reset = 1'b0;
    chk_en = 1'b1;
    tick();
    tick();
    check("idle_we", 32'(ctrl_writeEnable), 32'd0);

    // Pipeline wins the slot; the mult/div result drains on the next idle cycle.
    set_wb(1'b1, 5'd5, 32'hDEADBEEF);
    set_md(1'b1, 5'd7, 32'h12, 1'b0, 1'b0);
    query_rs = 5'd7;
    tick();
    check_write("prio_pipe", 5'd5, 32'hDEADBEEF);
    check("prio_hazard_on", 32'(hazard), 32'd1);
    set_wb(1'b0, 5'd0, 32'd0);
    set_md(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    tick();
    check_write("prio_drain", 5'd7, 32'h12);
    check("prio_hazard_off", 32'(hazard), 32'd0);
    query_rs = 5'd0;
    tick();
    check("hold_we",   32'(ctrl_writeEnable), 32'd0);
    check("hold_reg",  32'(ctrl_writeReg),    32'd7);
    check("hold_data", data_writeReg,         32'h12);

    // Fill the FIFO while the pipeline keeps writing r3.
    set_wb(1'b1, 5'd3, 32'h33);
    set_md(1'b1, 5'd8, 32'd1, 1'b0, 1'b0);
    tick();
    check_write("full_pipe0", 5'd3, 32'h33);
    set_md(1'b1, 5'd9, 32'd2, 1'b0, 1'b0);
    tick();
    check_write("full_pipe1", 5'd3, 32'h33);
    check("full_stall", 32'(pipe_stall), 32'd1);
    check("full_ready", 32'(md_ready),   32'd0);
    set_md(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    tick();
    check_write("full_pop_r8", 5'd8, 32'd1);
    check("full_unstall", 32'(pipe_stall), 32'd0);
    tick();
    check_write("full_resume_r3", 5'd3, 32'h33);
    set_wb(1'b0, 5'd0, 32'd0);
    tick();
    check_write("full_pop_r9", 5'd9, 32'd2);

    // Filtered pipeline writes leave the slot free for the FIFO.
    set_md(1'b1, 5'd10, 32'hA, 1'b0, 1'b0);
    tick();
    check("filt_enq_we", 32'(ctrl_writeEnable), 32'd0);
    set_md(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    set_wb(1'b1, 5'd0, 32'hBAD);
    tick();
    check_write("filt_r0_drain", 5'd10, 32'hA);
    set_wb(1'b0, 5'd0, 32'd0);
    set_md(1'b1, 5'd11, 32'hB, 1'b0, 1'b0);
    tick();
    set_md(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    set_wb(1'b1, 5'd1, 32'hBAD);
    tick();
    check_write("filt_r1_drain", 5'd11, 32'hB);
    set_wb(1'b0, 5'd0, 32'd0);
    set_md(1'b1, 5'd1, 32'h77, 1'b0, 1'b0);
    tick();
    check("filt_md_r1_we",    32'(ctrl_writeEnable), 32'd0);
    check("filt_md_r1_ready", 32'(md_ready),         32'd1);
    set_md(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    tick();
    check("filt_md_r1_nowr", 32'(ctrl_writeEnable), 32'd0);

    // Exceptions are rewritten to r30.
    query_rt = 5'd30;
    set_md(1'b1, 5'd4, 32'h99, 1'b1, 1'b1);
    tick();
    check("exc_div_hazard", 32'(hazard), 32'd1);
    set_md(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    tick();
    check_write("exc_div", 5'd30, 32'd5);
    set_md(1'b1, 5'd4, 32'h99, 1'b0, 1'b1);
    tick();
    set_md(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    tick();
    check_write("exc_mult", 5'd30, 32'd4);
    query_rt = 5'd0;

    // Back-to-back results with the pipeline idle: pointers wrap repeatedly.
    for (int i = 0; i < 10; i++) begin
      set_md(1'b1, 5'(12 + i), 32'h100 + 32'(i), 1'b0, 1'b0);
      check("wrap_ready", 32'(md_ready), 32'd1);
      tick();
      if (i > 0)
        check_write("wrap", 5'(12 + i - 1), 32'h100 + 32'(i - 1));
    end
    set_md(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    tick();
    check_write("wrap_last", 5'd21, 32'h109);
    tick();

    // Reset with two entries buffered discards them.
    set_wb(1'b1, 5'd6, 32'h66);
    set_md(1'b1, 5'd20, 32'h20, 1'b0, 1'b0);
    tick();
    set_md(1'b1, 5'd21, 32'h21, 1'b0, 1'b0);
    tick();
    check("rst2_full", 32'(pipe_stall), 32'd1);
    set_wb(1'b0, 5'd0, 32'd0);
    set_md(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    query_rs = 5'd20;
    #2 ctrl_reset = 1'b1;
    #1;
    check("rst2_we",     32'(ctrl_writeEnable), 32'd0);
    check("rst2_reg",    32'(ctrl_writeReg),    32'd0);
    check("rst2_data",   data_writeReg,         32'd0);
    check("rst2_ready",  32'(md_ready),         32'd1);
    check("rst2_stall",  32'(pipe_stall),       32'd0);
    check("rst2_hazard", 32'(hazard),           32'd0);
    tick();
    #2 ctrl_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst2_nowrite", 32'(ctrl_writeEnable), 32'd0);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Final write-port stage of the CPU pipeline, sitting directly upstream of the register file and driving its single write port (`ctrl_writeEnable`, `ctrl_writeReg`, `data_writeReg`). It merges two write sources into at most one register write per cycle:

- the in-order MEM/WB pipeline result;
- completed multi-cycle mult/div results, buffered in a small FIFO.

It also:

- drops writes to r0 (hardwired zero) and r1 (LFSR random source);
- redirects mult/div exceptions to r30 ($rstatus);
- flags read-after-write hazards against buffered results.

## Interface
Parameters:
- DEPTH, 2, mult/div result FIFO entries (power of two, ≥2)
- MULT_EXC, 32'd4, value written to r30 on mult exception
- DIV_EXC, 32'd5, value written to r30 on div exception

Ports:
- clock  in  1  sole clock, rising edge
- ctrl_reset  in  1  asynchronous, active-high reset
- wb_valid  in  1  pipeline writeback valid
- wb_rd  in  5  pipeline destination register
- wb_data  in  32  pipeline writeback data
- pipe_stall  out  1  combinational; pipeline must hold its WB slot this cycle
- md_valid  in  1  mult/div result offered
- md_ready  out  1  combinational; FIFO accepts the result this cycle
- md_rd  in  5  mult/div destination register
- md_data  in  32  mult/div result
- md_op  in  1  0 = mult, 1 = div
- md_exception  in  1  result is an exception
- query_rs, query_rt  in  5 each  decode-stage source registers
- hazard  out  1  combinational; a query matches a buffered entry's rd
- ctrl_writeEnable  out  1  registered regfile write enable
- ctrl_writeReg  out  5  registered regfile write address
- data_writeReg  out  32  registered regfile write data

## Operation
- **Filtering.** An rd of 0 or 1 on either source is treated as no write:
  - such a pipeline write occupies no slot;
  - such an md result is accepted (md_ready rules apply) but not enqueued.
- **Exception rewrite.** If md_exception=1, the enqueued entry is rd=30, data=MULT_EXC (md_op=0) or DIV_EXC (md_op=1), regardless of md_rd/md_data. Because the rewritten rd is 30, it is never filtered.
- **FIFO.**
  - DEPTH entries of {rd[4:0], data[31:0]}; count width $clog2(DEPTH)+1.
  - Read/write pointers wrap modulo DEPTH.
  - md_ready = (count != DEPTH).
  - Enqueue on md_valid & md_ready.
- **Slot selection each cycle** (priority order):
  1. FULL: count==DEPTH → pop FIFO head; pipe_stall=1; wb inputs ignored.
  2. PIPE: wb_valid and rd not in {0,1} → write pipeline result; pipe_stall=0.
  3. DRAIN: count>0 → pop FIFO head.
  4. IDLE: no write.
- **Stall.** pipe_stall is 1 only in FULL. It does not depend on wb_valid.
- **Simultaneous pop and enqueue.** Allowed in the same cycle; count is unchanged. In FULL, md_ready=0, so no simultaneous enqueue occurs when full.
- **Empty FIFO.** The same-cycle enqueued entry is never popped the cycle it enters. No bypass through an empty FIFO.
- **Hazard.** hazard=1 when query_rs or query_rt equals the rd of any valid FIFO entry. It ignores the current wb and the registered output stage, which the pipeline's own bypass network covers.
- **Ordering.** FIFO entries drain in arrival order. There is no ordering guarantee between the pipeline and FIFO sources; the hazard flag is the software/hardware contract.

## Timing
- **Reset.**
  - While ctrl_reset is high, asynchronously: ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, count=0, pointers=0.
  - Consequently md_ready=1, pipe_stall=0, hazard=0.
  - Reset mid-drain discards all buffered entries; no partial write is emitted.
- **Latency.** A selected write appears on the ctrl_write*/data_writeReg outputs at the clock edge after selection. The regfile captures it on the following edge.
  - Pipeline: 1 cycle input→outputs.
  - md result: ≥2 cycles (enqueue edge, then a pop edge).
- **Output hold.** Outputs are updated every cycle. When no write is selected, ctrl_writeEnable=0 and ctrl_writeReg/data_writeReg hold their previous values.
- **Combinational outputs.** md_ready, pipe_stall and hazard depend only on registered state and the query inputs; there is no path from md_valid or wb_valid.
- **Throughput.** Exactly one regfile write per cycle maximum.

## Test plan
- **Reset state.** Assert ctrl_reset mid-cycle → all outputs 0 immediately; md_ready=1. After release with no stimulus, writeEnable stays 0.
- **Pipeline priority with drain.**
  - Stimulus: wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF, and in the same cycle md_valid=1, md_rd=7, md_data=0x12, with the FIFO previously empty.
  - Required: next cycle write r5=0xDEADBEEF. With wb idle, the cycle after writes r7=0x12.
  - hazard=1 for query_rs=7 until r7 is popped.
- **Full FIFO.** Fill 2 md entries (r8=1, r9=2) while wb_valid stays high to r3:
  - pipe_stall=1 and md_ready=0 in the full cycle;
  - r8 is written first, then r3 resumes, then r9.
- **Filtering.**
  - wb_rd=0 and wb_rd=1 → no write; a pending FIFO entry drains in that slot.
  - md_rd=1 accepted → count unchanged, no write.
- **Exceptions.**
  - md_exception=1, md_op=1, md_rd=4 → write r30=5.
  - md_op=0 → write r30=4.
- **Wrap and reset.**
  - 10 back-to-back md results with pipeline idle → writes in order with pointers wrapping; count never exceeds 2.
  - Reset with 2 entries buffered → no writes after release.
